// File: rtl/rv_lsu_if.sv
// Bundle of the upstream request, data-memory port and writeback/fault signals of the load/store unit.
// The LSU takes the slave side; the environment (pipeline and memory) takes the master side.
interface rv_lsu_if;
    logic        i_valid;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [4:0]  i_rd;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_sel;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_fault;
    logic [1:0]  o_fault_code;

    modport slave (
        input  i_valid, i_load, i_store, i_funct3, i_addr, i_wdata, i_rd,
        input  i_mem_ack, i_mem_rdata,
        output o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_sel, o_mem_wdata,
        output o_wb_valid, o_wb_rd, o_wb_data, o_fault, o_fault_code
    );

    modport master (
        output i_valid, i_load, i_store, i_funct3, i_addr, i_wdata, i_rd,
        output i_mem_ack, i_mem_rdata,
        input  o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_sel, o_mem_wdata,
        input  o_wb_valid, o_wb_rd, o_wb_data, o_fault, o_fault_code
    );
endinterface

// File: rtl/rv_lsu.sv
// RV32 load/store unit: checks and latches one access, runs a single-outstanding req/ack
// memory transfer with lane steering and timeout, and returns extended load data to writeback.
module rv_lsu #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic    i_clk,
    input  logic    i_reset_n,
    rv_lsu_if.slave bus
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state, state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [4:0]      rd_p1;
    logic [2:0]      funct3_p1;
    logic [1:0]      off_p1;
    logic            accept, illegal, misaligned, to_hit;

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_sel = 4'b0001 << off;
            2'd1:    lane_sel = off[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'd0:    lane_wdata = {4{data[7:0]}};
            2'd1:    lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'd0:    load_extract = {{24{sh[7]}}, sh[7:0]};
            3'd1:    load_extract = {{16{sh[15]}}, sh[15:0]};
            3'd4:    load_extract = {24'd0, sh[7:0]};
            3'd5:    load_extract = {16'd0, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    assign bus.o_stall   = (state == ISSUE);
    assign bus.o_mem_req = (state == ISSUE);

    // The last ISSUE cycle before abort is the one where the counter reads TIMEOUT-1.
    assign to_hit = (TIMEOUT != 0) && (32'(to_cnt) == 32'(TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        illegal    = !(bus.i_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                     || (bus.i_funct3[2] && bus.i_store)
                     || (bus.i_load && bus.i_store);
        misaligned = ((bus.i_funct3[1:0] == 2'd1) && bus.i_addr[0])
                     || ((bus.i_funct3[1:0] == 2'd2) && (bus.i_addr[1:0] != 2'd0));
        accept     = (state == IDLE) && bus.i_valid && (bus.i_load || bus.i_store);
        case (state)
            IDLE:    if (accept && !illegal && !misaligned) state_nxt = ISSUE;
            ISSUE:   if (bus.i_mem_ack || to_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // p1: access fields latched at accept; result pulses one cycle after ack/abort
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            to_cnt           <= '0;
            rd_p1            <= '0;
            funct3_p1        <= '0;
            off_p1           <= '0;
            bus.o_mem_we     <= 1'b0;
            bus.o_mem_addr   <= '0;
            bus.o_mem_sel    <= '0;
            bus.o_mem_wdata  <= '0;
            bus.o_wb_valid   <= 1'b0;
            bus.o_wb_rd      <= '0;
            bus.o_wb_data    <= '0;
            bus.o_fault      <= 1'b0;
            bus.o_fault_code <= '0;
        end else begin
            bus.o_wb_valid <= 1'b0;
            bus.o_fault    <= 1'b0;
            if (accept) begin
                if (illegal || misaligned) begin
                    bus.o_fault      <= 1'b1;
                    bus.o_fault_code <= illegal ? 2'b11 : 2'b01;
                end else begin
                    to_cnt          <= '0;
                    rd_p1           <= bus.i_rd;
                    funct3_p1       <= bus.i_funct3;
                    off_p1          <= bus.i_addr[1:0];
                    bus.o_mem_we    <= bus.i_store;
                    bus.o_mem_addr  <= {bus.i_addr[31:2], 2'b00};
                    bus.o_mem_sel   <= lane_sel(bus.i_funct3[1:0], bus.i_addr[1:0]);
                    bus.o_mem_wdata <= lane_wdata(bus.i_funct3[1:0], bus.i_wdata);
                end
            end
            if (state == ISSUE) begin
                if (bus.i_mem_ack) begin
                    if (!bus.o_mem_we) begin
                        bus.o_wb_valid <= 1'b1;
                        bus.o_wb_rd    <= rd_p1;
                        bus.o_wb_data  <= load_extract(bus.i_mem_rdata, funct3_p1, off_p1);
                    end
                end else if (to_hit) begin
                    bus.o_fault      <= 1'b1;
                    bus.o_fault_code <= 2'b10;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_lsu.sv
// Directed and randomized bench for rv_lsu, checked against an arithmetic model of the access rules.
module tb_rv_lsu;
    localparam int TIMEOUT = 4;

    logic i_clk = 1'b0;
    logic i_reset_n;
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;

    rv_lsu_if bus();

    rv_lsu #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .bus      (bus)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] exp_code(input logic ld, input logic st, input logic [2:0] f3,
                                            input logic [31:0] addr);
        bit legal;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal || (ld && st) || (st && f3 >= 3'd4)) return 2'b11;
        if ((addr % nbytes(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        int v = ((1 << n) - 1) << (addr % 4);
        return 4'(v);
    endfunction

    // Byte lane i carries byte (i mod size) of the store operand.
    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = '0;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int n = nbytes(f3);
        logic [31:0] v;
        if (n == 4) return word;
        v = (word >> (8 * (addr % 4))) & ((32'd1 << (8 * n)) - 1);
        if (f3 < 3'd4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    // Presents one access, holds memory ack off for `delay` ISSUE cycles, and checks every cycle.
    task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int delay, input logic [31:0] rdat, input string tag);
        logic [1:0] code;
        int reqc;
        bit done;
        code = exp_code(ld, st, f3, addr);
        bus.i_valid = 1'b1; bus.i_load = ld; bus.i_store = st; bus.i_funct3 = f3;
        bus.i_addr = addr; bus.i_wdata = wd; bus.i_rd = rd;
        step();
        bus.i_valid = 1'b0; bus.i_load = 1'b0; bus.i_store = 1'b0;
        bus.i_addr = $urandom; bus.i_wdata = $urandom;
        if (code != 2'b00) begin
            check({tag, " fault"}, 32'(bus.o_fault), 32'd1);
            check({tag, " code"}, 32'(bus.o_fault_code), 32'(code));
            check({tag, " no req"}, 32'(bus.o_mem_req), 32'd0);
            check({tag, " no stall"}, 32'(bus.o_stall), 32'd0);
            step();
            check({tag, " fault one cycle"}, 32'(bus.o_fault), 32'd0);
            check({tag, " code holds"}, 32'(bus.o_fault_code), 32'(code));
        end else begin
            reqc = 0;
            done = 0;
            for (int w = 0; w < TIMEOUT && !done; w++) begin
                if (bus.o_mem_req) reqc++;
                check({tag, " stall"}, 32'(bus.o_stall), 32'd1);
                check({tag, " addr"}, bus.o_mem_addr, addr & ~32'h3);
                check({tag, " sel"}, 32'(bus.o_mem_sel), 32'(exp_sel(f3, addr)));
                check({tag, " we"}, 32'(bus.o_mem_we), 32'(st));
                if (st) check({tag, " wdata"}, bus.o_mem_wdata, exp_wdata(f3, wd));
                if (w == delay) begin
                    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = rdat;
                    step();
                    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = $urandom;
                    done = 1;
                    check({tag, " wb_valid"}, 32'(bus.o_wb_valid), 32'(ld));
                    check({tag, " stall after ack"}, 32'(bus.o_stall), 32'd0);
                    check({tag, " req after ack"}, 32'(bus.o_mem_req), 32'd0);
                    check({tag, " no fault"}, 32'(bus.o_fault), 32'd0);
                    if (ld) begin
                        check({tag, " wb_rd"}, 32'(bus.o_wb_rd), 32'(rd));
                        check({tag, " wb_data"}, bus.o_wb_data, exp_load(f3, addr, rdat));
                    end
                end else begin
                    step();
                    if (w == TIMEOUT - 1) begin
                        done = 1;
                        check({tag, " timeout fault"}, 32'(bus.o_fault), 32'd1);
                        check({tag, " timeout code"}, 32'(bus.o_fault_code), 32'd2);
                        check({tag, " timeout req"}, 32'(bus.o_mem_req), 32'd0);
                        check({tag, " timeout stall"}, 32'(bus.o_stall), 32'd0);
                        check({tag, " timeout no wb"}, 32'(bus.o_wb_valid), 32'd0);
                    end
                end
            end
            check({tag, " req cycles"}, 32'(reqc), 32'(delay < TIMEOUT ? delay + 1 : TIMEOUT));
        end
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        logic [2:0] f3;
        logic ld, st;
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        bus.i_valid = 1'b0; bus.i_load = 1'b0; bus.i_store = 1'b0; bus.i_funct3 = '0;
        bus.i_addr = '0; bus.i_wdata = '0; bus.i_rd = '0;
        bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
        i_reset_n = 1'b0;
        repeat (2) step();
        check("reset stall", 32'(bus.o_stall), 32'd0);
        check("reset req", 32'(bus.o_mem_req), 32'd0);
        check("reset mem_addr", bus.o_mem_addr, 32'd0);
        check("reset wb_data", bus.o_wb_data, 32'd0);
        check("reset fault_code", 32'(bus.o_fault_code), 32'd0);
        i_reset_n = 1'b1;
        step();

        access(1, 0, 3'd0, 32'h0000_1003, 32'h0, 5'd7, 0, 32'h80FF_1234, "LB");
        check("LB literal data", bus.o_wb_data, 32'hFFFF_FF80);
        step();
        check("wb pulse one cycle", 32'(bus.o_wb_valid), 32'd0);
        check("wb_data holds", bus.o_wb_data, 32'hFFFF_FF80);

        access(1, 0, 3'd5, 32'h0000_2002, 32'h0, 5'd19, 3, 32'h9ABC_0000, "LHU");
        check("LHU literal data", bus.o_wb_data, 32'h0000_9ABC);

        access(0, 1, 3'd0, 32'h0000_3001, 32'h1234_56A5, 5'd0, 0, 32'h0, "SB");
        access(0, 1, 3'd2, 32'h0000_3004, 32'hCAFE_F00D, 5'd0, 1, 32'h0, "SW b2b");
        access(0, 1, 3'd1, 32'h0000_3006, 32'h0000_BEEF, 5'd0, 0, 32'h0, "SH");

        access(1, 0, 3'd2, 32'h0000_4002, 32'h0, 5'd3, 0, 32'h0, "LW misaligned");
        access(1, 0, 3'd3, 32'h0000_4000, 32'h0, 5'd3, 0, 32'h0, "funct3=3");
        access(1, 1, 3'd2, 32'h0000_4000, 32'h0, 5'd3, 0, 32'h0, "load+store");
        access(0, 1, 3'd4, 32'h0000_4000, 32'h0, 5'd3, 0, 32'h0, "store BU");

        access(1, 0, 3'd2, 32'h0000_5000, 32'h0, 5'd9, 10, 32'h0, "timeout");
        access(1, 0, 3'd2, 32'h0000_5004, 32'h0, 5'd9, 3, 32'h1357_9BDF, "ack at expiry");

        // Reset in the middle of an open transfer; a late ack must be ignored.
        bus.i_valid = 1'b1; bus.i_load = 1'b1; bus.i_store = 1'b0; bus.i_funct3 = 3'd2;
        bus.i_addr = 32'h0000_6000; bus.i_wdata = 32'hFFFF_FFFF; bus.i_rd = 5'd4;
        step();
        bus.i_valid = 1'b0; bus.i_load = 1'b0;
        step();
        check("pre-reset req", 32'(bus.o_mem_req), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("mid reset req", 32'(bus.o_mem_req), 32'd0);
        check("mid reset stall", 32'(bus.o_stall), 32'd0);
        check("mid reset mem_addr", bus.o_mem_addr, 32'd0);
        check("mid reset sel", 32'(bus.o_mem_sel), 32'd0);
        check("mid reset wb_data", bus.o_wb_data, 32'd0);
        step();
        i_reset_n = 1'b1;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h1111_2222;
        step();
        check("late ack no wb", 32'(bus.o_wb_valid), 32'd0);
        check("late ack no req", 32'(bus.o_mem_req), 32'd0);
        check("late ack no fault", 32'(bus.o_fault), 32'd0);
        bus.i_mem_ack = 1'b0;
        access(1, 0, 3'd1, 32'h0000_7002, 32'h0, 5'd12, 1, 32'hF00D_1234, "LH after reset");

        for (int k = 0; k < 60; k++) begin
            ld = 1'($urandom_range(0, 1));
            st = !ld;
            if ($urandom_range(0, 11) == 0) begin ld = 1'b1; st = 1'b1; end
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = legal_f3[$urandom_range(0, 4)];
            access(ld, st, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom,
                   $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit; consumer of the ALU stage-2 result bus (effective address on `add`, `reg_data2`, `funct3`, `rd`, store/load select).
- Drives a single-outstanding req/ack data-memory port.
- Performs byte-lane steering for stores and extraction/extension for loads.
- Returns load data to writeback; stalls the pipeline while a bus transaction is open.

Parameters:
- TIMEOUT, 255, max cycles in ISSUE waiting for i_mem_ack before abort; 0 disables timeout.
- TO_W, 8, width of the timeout counter; TIMEOUT must be < 2^TO_W.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  upstream holds a valid instruction this cycle
- i_load  in  1  instruction is a load
- i_store  in  1  instruction is a store
- i_funct3  in  3  RV32 size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
- i_addr  in  32  effective address (ALU add result)
- i_wdata  in  32  store data (rs2)
- i_rd  in  5  load destination register
- o_stall  out  1  unit busy; upstream must hold its inputs
- o_mem_req  out  1  bus request
- o_mem_we  out  1  1 = write
- o_mem_addr  out  32  word address, {i_addr[31:2], 2'b00}
- o_mem_sel  out  4  byte enables
- o_mem_wdata  out  32  lane-steered write data
- i_mem_ack  in  1  transfer complete; rdata valid when !we
- i_mem_rdata  in  32  read word
- o_wb_valid  out  1  one-cycle pulse, load data valid
- o_wb_rd  out  5  load destination
- o_wb_data  out  32  extended load data
- o_fault  out  1  one-cycle pulse, access aborted
- o_fault_code  out  2  01 misaligned, 10 timeout, 11 illegal (bad funct3, or load & store both set)

Behaviour:
- Reset (async, i_reset_n low):
  - State goes to IDLE; timeout counter cleared.
  - All outputs 0, including o_mem_addr, o_mem_wdata, o_wb_data, o_fault_code.
  - An open request is dropped immediately; a later i_mem_ack is ignored.
- FSM states: IDLE, ISSUE.
- o_stall = (state == ISSUE), driven combinationally from state.
- Accept condition: in IDLE, i_valid & (i_load | i_store) is accepted at the clock edge, and all fields are registered.
- Checks on accept, priority order:
  1. illegal (funct3 not in {0,1,2,4,5}; funct3 4/5 with a store; load & store both set) → code 11.
  2. misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0) → code 01.
- Faulting access: no bus request; o_fault=1 for the next cycle only, with code; stays in IDLE.
- Good access: enter ISSUE next cycle, with o_mem_req=1.
  - o_mem_req, o_mem_we, o_mem_addr, o_mem_sel and o_mem_wdata stay stable until ack is sampled.
- Store steering:
  - SB: wdata = {4{b}}, sel = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, sel = addr[1] ? 1100 : 0011.
  - SW: sel = 1111.
- Load sel: same as the store pattern for the size.
- On edge with i_mem_ack=1 in ISSUE:
  - o_mem_req drops to 0 and state returns to IDLE next cycle.
  - For a load, next cycle o_wb_valid=1, o_wb_rd=rd, o_wb_data = selected lane:
    - B/H: sign-extended.
    - BU/HU: zero-extended.
    - W: unmodified.
  - For a store, no wb pulse.
- Minimum latency: accept at edge N, req high cycle N+1, ack sampled at edge N+1, wb_valid and stall low during cycle N+2.
- A new access may be accepted in the same cycle as o_wb_valid (back-to-back).
- i_mem_ack outside ISSUE is ignored.
- Timeout:
  - Counter clears on ISSUE entry and increments each ISSUE cycle without ack.
  - On reaching TIMEOUT: abort to IDLE, req low, o_fault=1 with code 10, no wb.
  - Ack on the same edge as expiry wins; the transfer completes normally.
- o_wb_data / o_fault_code hold their last value when the pulses are low.

Test Plan:
- LB, addr=0x1003, rdata=0x80FF_1234, ack in first ISSUE cycle → req for 1 cycle, sel=1000, addr=0x1000; wb_valid at N+2, data=0xFFFF_FF80.
- LHU, addr=0x2002, rdata=0x9ABC_0000, ack after 3 wait cycles → stall high 4 cycles, data=0x0000_9ABC, rd echoed.
- SB, addr=0x3001, wdata=0x1234_56A5 → we=1, sel=0010, o_mem_wdata=0xA5A5_A5A5, no wb_valid; back-to-back SW at 0x3004 accepted in the cycle after return to IDLE.
- Fault cases:
  - LW at 0x4002 → no req, o_fault pulse with code 01.
  - funct3=3 → code 11.
  - i_load=i_store=1 → code 11.
- TIMEOUT=4, no ack → req high exactly 4 cycles, then fault code 10; ack on the 4th cycle instead → normal completion, no fault.
- Reset asserted mid-ISSUE → req, stall, all outputs 0 immediately; late ack after release ignored; next load completes normally.
